// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the eight mux sources and the round-robin arbiter.
// The lock line exists only when MUX8_ARB_LOCK_EN is defined.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
`ifdef MUX8_ARB_LOCK_EN
  logic       lock;
`endif
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;

`ifdef MUX8_ARB_LOCK_EN
  modport master (input req, input lock, output sel, output gnt, output busy);
  modport slave  (output req, output lock, input sel, input gnt, input busy);
`else
  modport master (input req, output sel, output gnt, output busy);
  modport slave  (output req, input sel, input gnt, input busy);
`endif
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the sel bus of an 8-to-1 mux with bounded grant tenure.
// Optional grant lock enabled by defining MUX8_ARB_LOCK_EN.
module mux8_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  mux8_rr_arbiter_if.master         bus
);
  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   cur_q, cur_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            busy_q, busy_d;

  logic            lock_c;
  logic            at_limit_c;
  logic            release_c;
  logic [IW-1:0]   start_c;
  logic [IW-1:0]   scan_idx_c;
  logic            win_c;
  logic [IW-1:0]   win_idx_c;

`ifdef MUX8_ARB_LOCK_EN
  assign lock_c = bus.lock;
`else
  assign lock_c = 1'b0;
`endif

  assign at_limit_c = (cnt_q == HOLD_C);
  assign release_c  = !bus.req[cur_q] || (at_limit_c && !lock_c);
  // On release the search restarts just past the current owner.
  assign start_c    = (state_q == GRANT) ? IW'(cur_q + IW'(1)) : ptr_q;

  // First set request scanning upward from start_c, mod 8
  always_comb begin
    win_c      = 1'b0;
    win_idx_c  = '0;
    scan_idx_c = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      scan_idx_c = IW'(start_c + IW'(k));
      if (bus.req[scan_idx_c]) begin
        win_c     = 1'b1;
        win_idx_c = scan_idx_c;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (win_c) state_d = GRANT;
    end else begin
      if (release_c && !win_c) state_d = IDLE;
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    ptr_d  = ptr_q;
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    gnt_d  = gnt_q;
    busy_d = busy_q;
    if (state_q == IDLE || release_c) begin
      if (state_q == GRANT) ptr_d = IW'(cur_q + IW'(1));
      if (win_c) begin
        cur_d  = win_idx_c;
        cnt_d  = CW'(1);
        gnt_d  = N'(1) << win_idx_c;
        busy_d = 1'b1;
      end else begin
        cnt_d  = '0;
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    end else if (!at_limit_c) begin
      cnt_d = CW'(cnt_q + CW'(1));
    end
    // A locked owner at the limit keeps cnt saturated.
    sel_d = cur_d;
  end

  assign bus.sel  = sel_q;
  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized and directed self-checking bench for mux8_rr_arbiter against a cycle-level
// round-robin model; the lock scenario runs only when MUX8_ARB_LOCK_EN is defined.
module tb_mux8_rr_arbiter;
`ifdef MUX8_ARB_LOCK_EN
  localparam int HOLD = 2;
`else
  localparam int HOLD = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Model state: owner index or -1 when idle
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_sel   = 0;
  int   m_ten   = 0;

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] exp_gnt();
    logic [7:0] one;
    one = 8'd1;
    return (m_owner < 0) ? 8'h00 : (one << m_owner);
  endfunction

  function automatic logic lock_val();
`ifdef MUX8_ARB_LOCK_EN
    return bus.lock;
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock and apply the round-robin rules to the model
  task automatic tick();
    int w;
    logic [7:0] r;
    @(posedge clk);
    r = bus.req;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_ten = 0;
    end else if (m_owner < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin m_owner = w; m_sel = w; m_ten = 1; end
    end else if (!r[m_owner] || (m_ten >= HOLD && !lock_val())) begin
      m_ptr = (m_owner + 1) % 8;
      w = pick(r, m_ptr);
      if (w >= 0) begin m_owner = w; m_sel = w; m_ten = 1; end
      else m_owner = -1;
    end else if (m_ten < HOLD) begin
      m_ten++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.gnt !== 8'h00 || bus.sel !== 3'd0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got gnt=%h sel=%0d busy=%b exp gnt=00 sel=0 busy=0",
                 i, bus.gnt, bus.sel, bus.busy);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant got gnt=%h sel=%0d busy=%b exp gnt=01 sel=0 busy=1",
               bus.gnt, bus.sel, bus.busy);
    end
  endtask

  // Continues straight from test_reset: cycle 0 was the first grant
  task automatic test_rotation();
    int exp_sel;
    for (int j = 1; j <= 8 * HOLD; j++) begin
      tick();
      exp_sel = (j / HOLD) % 8;
      checks++;
      if (bus.sel !== 3'(exp_sel) || bus.busy !== 1'b1 || bus.gnt !== exp_gnt()) begin
        errors++;
        $display("FAIL rotation cyc=%0d got sel=%0d busy=%b gnt=%h exp sel=%0d busy=1 gnt=%h",
                 j, bus.sel, bus.busy, bus.gnt, exp_sel, exp_gnt());
      end
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    bus.req = 8'h24;
    tick();
    tick();
    checks++;
    if (bus.gnt !== 8'h04 || bus.sel !== 3'd2) begin
      errors++;
      $display("FAIL drop_second_cycle got gnt=%h sel=%0d exp gnt=04 sel=2", bus.gnt, bus.sel);
    end
    bus.req = 8'h20;
    tick();
    checks++;
    if (bus.gnt !== 8'h20 || bus.sel !== 3'd5 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_handover got gnt=%h sel=%0d busy=%b exp gnt=20 sel=5 busy=1",
               bus.gnt, bus.sel, bus.busy);
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || bus.sel !== 3'd5) begin
      errors++;
      $display("FAIL drop_idle got gnt=%h busy=%b sel=%0d exp gnt=00 busy=0 sel=5",
               bus.gnt, bus.busy, bus.sel);
    end
  endtask

  task automatic test_sole_wrap();
    do_reset();
    bus.req = 8'h80;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (bus.gnt !== 8'h80 || bus.sel !== 3'd7 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL sole_hold cyc=%0d got gnt=%h sel=%0d busy=%b exp gnt=80 sel=7 busy=1",
                 i, bus.gnt, bus.sel, bus.busy);
      end
    end
    // 12 cycles ends a tenure exactly, so the wrapped pointer favours index 0 next
    bus.req = 8'h81;
    tick();
    checks++;
    if (bus.gnt !== 8'h01 || bus.sel !== 3'd0) begin
      errors++;
      $display("FAIL sole_wrap got gnt=%h sel=%0d exp gnt=01 sel=0", bus.gnt, bus.sel);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req = 8'h10;
    tick(); tick(); tick();
    checks++;
    if (bus.gnt !== 8'h10 || bus.sel !== 3'd4) begin
      errors++;
      $display("FAIL midrst_pre got gnt=%h sel=%0d exp gnt=10 sel=4", bus.gnt, bus.sel);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 8'h00 || bus.sel !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got gnt=%h sel=%0d busy=%b exp gnt=00 sel=0 busy=0",
               bus.gnt, bus.sel, bus.busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 8'h10 || bus.sel !== 3'd4 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_resume got gnt=%h sel=%0d busy=%b exp gnt=10 sel=4 busy=1",
               bus.gnt, bus.sel, bus.busy);
    end
    // A fresh tenure: with index 3 added, the owner keeps the lane for HOLD cycles total
    bus.req = 8'h18;
    for (int i = 1; i <= HOLD; i++) begin
      tick();
      checks++;
      if (bus.gnt !== exp_gnt()) begin
        errors++;
        $display("FAIL midrst_tenure cyc=%0d got gnt=%h exp gnt=%h", i, bus.gnt, exp_gnt());
      end
    end
  endtask

`ifdef MUX8_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.req  = 8'h03;
    bus.lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.gnt !== 8'h01 || bus.sel !== 3'd0) begin
        errors++;
        $display("FAIL lock_hold cyc=%0d got gnt=%h sel=%0d exp gnt=01 sel=0",
                 i, bus.gnt, bus.sel);
      end
    end
    bus.lock = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 8'h02 || bus.sel !== 3'd1) begin
      errors++;
      $display("FAIL lock_release got gnt=%h sel=%0d exp gnt=02 sel=1", bus.gnt, bus.sel);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] one;
    one = 8'd1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)
        bus.req = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      rst = ($urandom_range(0, 59) == 0);
`ifdef MUX8_ARB_LOCK_EN
      bus.lock = ($urandom_range(0, 2) == 0);
`endif
      tick();
      checks++;
      if (bus.gnt !== exp_gnt() || bus.sel !== 3'(m_sel) || bus.busy !== (m_owner >= 0)) begin
        errors++;
        $display("FAIL random cyc=%0d req=%h got gnt=%h sel=%0d busy=%b exp gnt=%h sel=%0d busy=%b",
                 i, bus.req, bus.gnt, bus.sel, bus.busy, exp_gnt(), m_sel, (m_owner >= 0));
      end
      checks++;
      if (!$onehot0(bus.gnt) || (bus.busy && bus.gnt !== (one << bus.sel))) begin
        errors++;
        $display("FAIL invariant cyc=%0d got gnt=%h sel=%0d busy=%b exp one-hot gnt matching sel",
                 i, bus.gnt, bus.sel, bus.busy);
      end
    end
    rst = 1'b0;
`ifdef MUX8_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
  endtask

  initial begin
    bus.req = 8'h00;
`ifdef MUX8_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    #1;
    test_reset();
    test_rotation();
    test_early_drop();
    test_sole_wrap();
    test_mid_reset();
`ifdef MUX8_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
